// File: rtl/rll_key_sched.sv
// Key provisioning controller for an RLL-locked core. It fetches the unlock key in
// chunks from a key store, self-checks it on the core, and only then releases it.
module rll_key_sched #(
   parameter int KEY_W      = 32,
   parameter int DATA_W     = 32,
   parameter int CHUNK_W    = 8,
   parameter int SETTLE_CYC = 2,
   parameter int MAX_TRY    = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             clear,
   output logic                             nvm_req,
   output logic [$clog2(KEY_W/CHUNK_W)-1:0] nvm_addr,
   input  logic                             nvm_ack,
   input  logic [CHUNK_W-1:0]               nvm_data,
   input  logic [DATA_W-1:0]                chk_pattern,
   input  logic [DATA_W-1:0]                chk_expect,
   input  logic [DATA_W-1:0]                core_out,
   output logic [KEY_W-1:0]                 core_key,
   output logic                             sel_test,
   output logic                             busy,
   output logic                             key_valid,
   output logic                             key_fail
);
   localparam int            NCHUNK      = KEY_W / CHUNK_W;
   localparam int            AW          = $clog2(NCHUNK);
   localparam logic [AW-1:0] LAST_CHUNK  = AW'(NCHUNK - 1);
   localparam logic [2:0]    MAX_T       = 3'(MAX_TRY);
   localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {IDLE, FETCH, SETTLE, CHECK, DONE, FAIL} state_t;

   state_t            state, state_d;
   logic [KEY_W-1:0]  staging, staging_d;
   logic [AW-1:0]     chunk, chunk_d;
   logic [2:0]        try_cnt, try_d;
   logic [3:0]        settle_cnt, settle_d;
   logic [DATA_W-1:0] pat_q, pat_d;
   logic [KEY_W-1:0]  core_key_d;
   logic              req_d, sel_d, busy_d, valid_d, fail_d;
   logic              resp_ok;

   assign nvm_addr = chunk;

   // A pattern that moved while being applied invalidates the sampled response.
   assign resp_ok = (core_out == chk_expect) && (chk_pattern == pat_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         staging    <= '0;
         chunk      <= '0;
         try_cnt    <= '0;
         settle_cnt <= '0;
         pat_q      <= '0;
         nvm_req    <= 1'b0;
         core_key   <= '0;
         sel_test   <= 1'b0;
         busy       <= 1'b0;
         key_valid  <= 1'b0;
         key_fail   <= 1'b0;
      end else begin
         state      <= state_d;
         staging    <= staging_d;
         chunk      <= chunk_d;
         try_cnt    <= try_d;
         settle_cnt <= settle_d;
         pat_q      <= pat_d;
         nvm_req    <= req_d;
         core_key   <= core_key_d;
         sel_test   <= sel_d;
         busy       <= busy_d;
         key_valid  <= valid_d;
         key_fail   <= fail_d;
      end
   end

   always_comb begin
      state_d   = state;
      staging_d = staging;
      chunk_d   = chunk;
      try_d     = try_cnt;
      settle_d  = settle_cnt;
      pat_d     = pat_q;
      req_d     = 1'b0;

      if (clear) begin
         state_d   = IDLE;
         staging_d = '0;
         chunk_d   = '0;
         try_d     = '0;
         settle_d  = '0;
      end else begin
         case (state)
            IDLE, DONE, FAIL: begin
               if (start) begin
                  state_d   = FETCH;
                  staging_d = '0;
                  chunk_d   = '0;
                  try_d     = 3'd1;
               end
            end
            // The request toggles low for one cycle after every accepted chunk.
            FETCH: begin
               if (nvm_req && nvm_ack) begin
                  staging_d[chunk*CHUNK_W +: CHUNK_W] = nvm_data;
                  if (chunk == LAST_CHUNK) begin
                     state_d  = SETTLE;
                     chunk_d  = '0;
                     settle_d = '0;
                     pat_d    = chk_pattern;
                  end else begin
                     chunk_d = chunk + 1'b1;
                  end
               end else begin
                  req_d = 1'b1;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state_d = CHECK;
               end else begin
                  settle_d = settle_cnt + 1'b1;
               end
            end
            CHECK: begin
               if (resp_ok) begin
                  state_d = DONE;
               end else if (try_cnt < MAX_T) begin
                  state_d   = FETCH;
                  try_d     = try_cnt + 1'b1;
                  chunk_d   = '0;
                  staging_d = '0;
               end else begin
                  state_d = FAIL;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Registered outputs follow the next state, so a partial key never leaves the block.
      core_key_d = (state_d inside {SETTLE, CHECK, DONE}) ? staging_d : '0;
      sel_d      = (state_d inside {SETTLE, CHECK});
      busy_d     = (state_d inside {FETCH, SETTLE, CHECK});
      valid_d    = (state_d == DONE);
      fail_d     = (state_d == FAIL);
   end
endmodule
